// File: rtl/wb_hilo_cp0.sv
// Writeback stage: GPR write port, architectural HI/LO and the CP0 subset (Status/Cause/EPC).
// Define CP0_TIMER_EN to build the Count/Compare timer and its interrupt request.
module wb_hilo_cp0 #(
   parameter int         CNT_DIV = 2,
   parameter logic [4:0] EXC_SYS = 5'd8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wr_dout,
   input  logic [31:0] wr_result,
   input  logic [31:0] wr_HL,
   input  logic [31:0] wr_cp0_dout,
   input  logic [63:0] wr_mult,
   input  logic [31:0] wr_busA_mux2,
   input  logic [31:0] wr_busB_mux2,
   input  logic [31:0] wr_pc,
   input  logic [4:0]  wr_rw,
   input  logic        wr_regWr,
   input  logic        wr_multWr,
   input  logic        wr_Highin,
   input  logic        wr_Lowin,
   input  logic [1:0]  wr_memtoreg,
   input  logic [2:0]  wr_cp0op,
   input  logic [4:0]  wr_cs,
   input  logic [2:0]  wr_sel,
   input  logic [4:0]  cp0_raddr,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] cp0_rdata,
   output logic [31:0] epc,
   output logic        exl,
   output logic        int_req
);

   localparam logic [2:0] OP_MTC0    = 3'b001;
   localparam logic [2:0] OP_SYSCALL = 3'b011;
   localparam logic [2:0] OP_ERET    = 3'b100;

   localparam logic [4:0] A_COUNT   = 5'd9;
   localparam logic [4:0] A_COMPARE = 5'd11;
   localparam logic [4:0] A_STATUS  = 5'd12;
   localparam logic [4:0] A_CAUSE   = 5'd13;
   localparam logic [4:0] A_EPC     = 5'd14;

   if (CNT_DIV < 1 || CNT_DIV > 4) begin : g_bad_cnt_div
      $error("CNT_DIV must be in 1..4");
   end

   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d;
   logic        mtc0_en;

   assign rf_we    = wr_regWr & (wr_rw != 5'd0);
   assign rf_waddr = wr_rw;

   always_comb begin
      rf_wdata = wr_result;
      case (wr_memtoreg)
         2'd0:    rf_wdata = wr_result;
         2'd1:    rf_wdata = wr_dout;
         2'd2:    rf_wdata = wr_HL;
         default: rf_wdata = wr_cp0_dout;
      endcase
   end

   // A multiply result overrides any mthi/mtlo retiring in the same cycle.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (wr_multWr) begin
         {hi_d, lo_d} = wr_mult;
      end else begin
         if (wr_Highin) hi_d = wr_busA_mux2;
         if (wr_Lowin)  lo_d = wr_busA_mux2;
      end
   end

   assign mtc0_en = (wr_cp0op == OP_MTC0) && (wr_sel == 3'd0);

`ifdef CP0_TIMER_EN
   logic [31:0] count_q, count_d, compare_q, compare_d;
   logic [1:0]  div_q, div_d;
   logic        div_wrap;

   assign div_wrap = (div_q == 2'(CNT_DIV - 1));
`endif

   always_comb begin
      status_d = status_q;
      cause_d  = cause_q;
      epc_d    = epc_q;
      if (wr_cp0op == OP_SYSCALL) begin
         epc_d        = wr_pc;
         cause_d[6:2] = EXC_SYS;
         status_d[1]  = 1'b1;
      end else if (wr_cp0op == OP_ERET) begin
         status_d[1] = 1'b0;
      end else if (mtc0_en) begin
         case (wr_cs)
            A_STATUS: status_d     = wr_busB_mux2;
            A_CAUSE:  cause_d[9:8] = wr_busB_mux2[9:8];
            A_EPC:    epc_d        = wr_busB_mux2;
            default:  ;
         endcase
      end
`ifdef CP0_TIMER_EN
      count_d   = div_wrap ? count_q + 32'd1 : count_q;
      div_d     = div_wrap ? 2'd0 : div_q + 2'd1;
      compare_d = compare_q;
      if (mtc0_en && wr_cs == A_COUNT) begin
         count_d = wr_busB_mux2;
         div_d   = 2'd0;
      end
      // The timer flag is sticky; only a Compare write clears it, even against a live match.
      if (count_q == compare_q && compare_q != 32'd0) cause_d[15] = 1'b1;
      if (mtc0_en && wr_cs == A_COMPARE) begin
         compare_d   = wr_busB_mux2;
         cause_d[15] = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q     <= '0;
         lo_q     <= '0;
         status_q <= '0;
         cause_q  <= '0;
         epc_q    <= '0;
`ifdef CP0_TIMER_EN
         count_q   <= '0;
         compare_q <= '0;
         div_q     <= '0;
`endif
      end else begin
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         status_q <= status_d;
         cause_q  <= cause_d;
         epc_q    <= epc_d;
`ifdef CP0_TIMER_EN
         count_q   <= count_d;
         compare_q <= compare_d;
         div_q     <= div_d;
`endif
      end
   end

   always_comb begin
      cp0_rdata = 32'd0;
      case (cp0_raddr)
         A_STATUS:  cp0_rdata = status_q;
         A_CAUSE:   cp0_rdata = cause_q;
         A_EPC:     cp0_rdata = epc_q;
`ifdef CP0_TIMER_EN
         A_COUNT:   cp0_rdata = count_q;
         A_COMPARE: cp0_rdata = compare_q;
`endif
         default:   cp0_rdata = 32'd0;
      endcase
   end

   assign hi  = hi_q;
   assign lo  = lo_q;
   assign epc = epc_q;
   assign exl = status_q[1];

`ifdef CP0_TIMER_EN
   assign int_req = cause_q[15] & status_q[15] & status_q[0] & ~status_q[1];
`else
   assign int_req = 1'b0;
`endif

endmodule
